// File: rtl/tff_counter_ctrl_if.sv
// tff_counter_ctrl_if: control/status bundle between the sequencing controller and its environment
interface tff_counter_ctrl_if #(
  parameter int CNT_W = 4,
  parameter int PER_W = 8
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             periodic;
  logic [CNT_W-1:0] terminal;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_en;
  logic             cnt_clr;
  logic             busy;
  logic             done;
  logic [PER_W-1:0] period_cnt;
  modport master (
    output start, stop, pause, periodic, terminal, cnt_val,
    input  cnt_en, cnt_clr, busy, done, period_cnt
  );
  modport slave (
    input  start, stop, pause, periodic, terminal, cnt_val,
    output cnt_en, cnt_clr, busy, done, period_cnt
  );
endinterface

// File: rtl/tff_counter_ctrl.sv
// tff_counter_ctrl: sequences a T-flip-flop counter through one-shot or periodic count-to-terminal runs
module tff_counter_ctrl #(
  parameter int CNT_W = 4,
  parameter int PER_W = 8
) (
  input logic              clk,
  input logic              reset,
  tff_counter_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, PAUSE, DONE} state_e;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] term_q, term_d;
  logic             mode_q, mode_d;
  logic [PER_W-1:0] per_q, per_d;
  logic             hit;
  assign hit            = bus.cnt_val == term_q;
  assign bus.period_cnt = per_q;
  assign bus.busy       = state_q == CLEAR || state_q == RUN || state_q == PAUSE;
  assign bus.done       = state_q == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      term_q  <= '0;
      mode_q  <= 1'b0;
      per_q   <= '0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      mode_q  <= mode_d;
      per_q   <= per_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    term_d      = term_q;
    mode_d      = mode_q;
    per_d       = per_q;
    bus.cnt_en  = 1'b0;
    bus.cnt_clr = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        term_d  = bus.terminal;
        mode_d  = bus.periodic;
        per_d   = '0;
        state_d = CLEAR;
      end
      CLEAR: begin
        bus.cnt_clr = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        // the compare gate keeps the counter from ever stepping past term_q
        bus.cnt_en = !hit && !bus.pause && !bus.stop;
        if (bus.stop) state_d = IDLE;
        else if (hit) begin
          state_d = mode_q ? CLEAR : DONE;
          per_d   = mode_q ? per_q + PER_W'(1) : per_q;
        end else if (bus.pause) state_d = PAUSE;
      end
      PAUSE: state_d = bus.stop ? IDLE : (bus.pause ? PAUSE : RUN);
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_tff_counter_ctrl.sv
// tb_tff_counter_ctrl: random control stimulus against a flag-based behavioural model plus a counter datapath
module tb_tff_counter_ctrl;
  localparam int CNT_W = 4;
  localparam int PER_W = 2;
  logic clk = 1'b0;
  logic reset;
  logic [CNT_W-1:0] y;
  int n_cmp = 0;
  int n_bad = 0;
  tff_counter_ctrl_if #(.CNT_W(CNT_W), .PER_W(PER_W)) bus ();
  tff_counter_ctrl #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always_ff @(posedge clk) begin
    if (reset || bus.cnt_clr) y <= '0;
    else if (bus.cnt_en) y <= y + 1'b1;
  end
  assign bus.cnt_val = y;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask
  bit m_busy, m_clear, m_hold, m_fin, m_mode;
  int m_term, m_pcnt, m_y;
  bit e_en;
  bit r, st, sp, pa, pe;
  int te;
  initial begin
    reset = 1'b1;
    {bus.start, bus.stop, bus.pause, bus.periodic} = '0;
    bus.terminal = '0;
    {m_busy, m_clear, m_hold, m_fin, m_mode} = '0;
    m_term = 0; m_pcnt = 0; m_y = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 4000; c++) begin
      r  = $urandom_range(0, 299) == 0;
      st = $urandom_range(0, 3) == 0;
      sp = $urandom_range(0, 59) == 0;
      pa = $urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 0 : 2);
      pe = $urandom_range(0, 1) == 1;
      te = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 15);
      reset = r; bus.start = st; bus.stop = sp; bus.pause = pa; bus.periodic = pe;
      bus.terminal = CNT_W'(te);
      @(negedge clk);
      e_en = m_busy && !m_clear && !m_hold && !m_fin && m_y != m_term && !pa && !sp;
      chk("cnt_en", 32'(bus.cnt_en), 32'(e_en));
      chk("cnt_clr", 32'(bus.cnt_clr), 32'(m_clear));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_fin));
      chk("period_cnt", 32'(bus.period_cnt), 32'(m_pcnt));
      chk("cnt_val", 32'(y), 32'(m_y));
      @(posedge clk);
      #1;
      if (r) begin
        {m_busy, m_clear, m_hold, m_fin, m_mode} = '0;
        m_term = 0; m_pcnt = 0; m_y = 0;
      end else begin
        if (m_clear) m_y = 0;
        else if (e_en) m_y = (m_y + 1) % 16;
        if (m_fin) m_fin = 0;
        else if (!m_busy) begin
          if (st) begin
            m_term = te; m_mode = pe; m_pcnt = 0; m_busy = 1; m_clear = 1;
          end
        end else if (m_clear) m_clear = 0;
        else if (sp) begin
          m_busy = 0; m_hold = 0;
        end else if (m_hold) m_hold = pa;
        else if (m_y_prev_hit(m_y, e_en, m_term)) begin
          if (m_mode) begin
            m_clear = 1; m_pcnt = (m_pcnt + 1) % (1 << PER_W);
          end else begin
            m_busy = 0; m_fin = 1;
          end
        end else if (pa) m_hold = 1;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  // the counter was sampled before its update: undo the step to recover the value RUN compared
  function automatic bit m_y_prev_hit(input int y_now, input bit stepped, input int term);
    return (stepped ? (y_now + 15) % 16 : y_now) == term;
  endfunction
endmodule
